// File: rtl/tetris_pkg.sv
// Shared types for the piece-movement logic: move codes, proposer FSM states
// and the pending-request priority helpers.
package tetris_pkg;

    typedef enum logic [2:0] {
        MV_GRAV = 3'd0,
        MV_ROT  = 3'd1,
        MV_LFT  = 3'd2,
        MV_RGT  = 3'd3,
        MV_DN   = 3'd4
    } move_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PROPOSE = 2'd1,
        ST_WAIT    = 2'd2
    } state_t;

    localparam int NUM_MOVES = 5;

    // One sticky request bit per move, indexed by the move_t value.
    typedef logic [NUM_MOVES-1:0] pend_t;

    // Lower move code wins: grav > rot > lft > rgt > dn.
    function automatic move_t pick_move(input pend_t p);
        move_t m;
        m = MV_DN;
        if (p[4]) m = MV_DN;
        if (p[3]) m = MV_RGT;
        if (p[2]) m = MV_LFT;
        if (p[1]) m = MV_ROT;
        if (p[0]) m = MV_GRAV;
        return m;
    endfunction

    function automatic pend_t move_mask(input move_t m);
        return pend_t'(1) << m;
    endfunction

endpackage

// File: rtl/move_proposer_if.sv
// Proposal/verdict handshake between the move proposer (master) and the
// collision checker (slave).
interface move_proposer_if #(
    parameter int X_W    = 4,
    parameter int Y_W    = 5,
    parameter int TYPE_W = 5
);
    logic [TYPE_W-1:0] test_type;
    logic [X_W-1:0]    test_x;
    logic [Y_W-1:0]    test_y;
    logic              prop_valid;
    logic              chk_done;
    logic              chk_ok;

    modport master (
        output test_type, test_x, test_y, prop_valid,
        input  chk_done, chk_ok
    );

    modport slave (
        input  test_type, test_x, test_y, prop_valid,
        output chk_done, chk_ok
    );
endinterface

// File: rtl/move_proposer_das_counter.sv
// Delayed auto-shift counter for one horizontal direction; instantiated by
// move_proposer only when AUTO_REPEAT_EN is defined.
module das_counter #(
    parameter int DAS_DLY = 12,
    parameter int DAS_RPT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic hold,
    output logic rpt
);
    localparam int MAX_CNT = (DAS_DLY > DAS_RPT) ? DAS_DLY : DAS_RPT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;
    logic             repeating;

    // The first repeat waits the long delay, later ones the short period.
    assign limit = repeating ? CNT_W'(DAS_RPT) : CNT_W'(DAS_DLY);
    assign rpt   = hold && tick && (cnt == limit - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            repeating <= 1'b0;
        end else if (!hold) begin
            cnt       <= '0;
            repeating <= 1'b0;
        end else if (tick) begin
            if (rpt) begin
                cnt       <= '0;
                repeating <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/move_proposer.sv
// Turns button edges and gravity ticks into one-at-a-time piece move proposals
// for an external checker. Define AUTO_REPEAT_EN to enable left/right auto-repeat.
module move_proposer
    import tetris_pkg::*;
#(
    parameter int X_W     = 4,
    parameter int Y_W     = 5,
    parameter int TYPE_W  = 5,
    parameter int ROT_W   = 2,
    parameter int DAS_DLY = 12,
    parameter int DAS_RPT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              spawn,
    input  logic [TYPE_W-1:0] spawn_type,
    input  logic [X_W-1:0]    spawn_x,
    input  logic [Y_W-1:0]    spawn_y,
    input  logic              gravity,
    input  logic              tick,
    input  logic              rotate,
    input  logic              left,
    input  logic              right,
    input  logic              down,
    output logic [TYPE_W-1:0] cur_type,
    output logic [X_W-1:0]    cur_x,
    output logic [Y_W-1:0]    cur_y,
    output logic              lock_pulse,
    move_proposer_if.master   chk
);
    state_t            state, state_nxt;
    move_t             sel;
    pend_t             pend, pend_set, pend_clr;
    logic [3:0]        btn_prev;
    logic              rot_rise, lft_rise, rgt_rise, dn_rise;
    logic              lft_rpt, rgt_rpt;
    logic              take, accept, lock_nxt;
    logic [TYPE_W-1:0] prop_type, nxt_type;
    logic [X_W-1:0]    prop_x, nxt_x;
    logic [Y_W-1:0]    prop_y, nxt_y;
    logic [ROT_W-1:0]  rot_inc;

    assign rot_rise = rotate & ~btn_prev[3];
    assign lft_rise = left   & ~btn_prev[2];
    assign rgt_rise = right  & ~btn_prev[1];
    assign dn_rise  = down   & ~btn_prev[0];

`ifdef AUTO_REPEAT_EN
    das_counter #(.DAS_DLY(DAS_DLY), .DAS_RPT(DAS_RPT)) u_das_lft (
        .clk(clk), .rst_n(rst_n), .tick(tick), .hold(left & ~right), .rpt(lft_rpt)
    );
    das_counter #(.DAS_DLY(DAS_DLY), .DAS_RPT(DAS_RPT)) u_das_rgt (
        .clk(clk), .rst_n(rst_n), .tick(tick), .hold(right & ~left), .rpt(rgt_rpt)
    );
`else
    localparam int unused_das = DAS_DLY + DAS_RPT;
    logic unused_tick;
    assign unused_tick = tick;
    assign lft_rpt     = 1'b0;
    assign rgt_rpt     = 1'b0;
`endif

    assign pend_set = {dn_rise, rgt_rise | rgt_rpt, lft_rise | lft_rpt, rot_rise, gravity};
    assign pend_clr = take ? move_mask(pick_move(pend)) : '0;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        accept    = 1'b0;
        lock_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mode != 2'b00 && pend != '0) begin
                    take      = 1'b1;
                    state_nxt = ST_PROPOSE;
                end
            end
            ST_PROPOSE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (chk.chk_done) begin
                    state_nxt = ST_IDLE;
                    accept    = chk.chk_ok;
                    lock_nxt  = !chk.chk_ok && (sel == MV_GRAV || sel == MV_DN);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A spawn replaces the piece, so whatever was in flight is void.
        if (spawn) begin
            state_nxt = ST_IDLE;
            take      = 1'b0;
            accept    = 1'b0;
            lock_nxt  = 1'b0;
        end
    end

    assign rot_inc = cur_type[ROT_W-1:0] + ROT_W'(1);

    always_comb begin
        nxt_type = cur_type;
        nxt_x    = cur_x;
        nxt_y    = cur_y;
        case (sel)
            MV_GRAV, MV_DN: nxt_y = cur_y + Y_W'(1);
            MV_ROT:         nxt_type = {cur_type[TYPE_W-1:ROT_W], rot_inc};
            MV_LFT:         nxt_x = cur_x - X_W'(1);
            MV_RGT:         nxt_x = cur_x + X_W'(1);
            default:        ;
        endcase
    end

    // NOTE: all state here is register-only (no memories), so the whole block resets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sel        <= MV_GRAV;
            pend       <= '0;
            btn_prev   <= '0;
            cur_type   <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            prop_type  <= '0;
            prop_x     <= '0;
            prop_y     <= '0;
            lock_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_nxt;
            btn_prev   <= {rotate, left, right, down};
            lock_pulse <= lock_nxt;
            pend       <= spawn ? pend_t'(0) : ((pend & ~pend_clr) | pend_set);
            if (take) sel <= pick_move(pend);
            if (state == ST_PROPOSE) begin
                prop_type <= nxt_type;
                prop_x    <= nxt_x;
                prop_y    <= nxt_y;
            end
            if (spawn) begin
                cur_type <= spawn_type;
                cur_x    <= spawn_x;
                cur_y    <= spawn_y;
            end else if (accept) begin
                cur_type <= prop_type;
                cur_x    <= prop_x;
                cur_y    <= prop_y;
            end
        end
    end

    assign chk.prop_valid = (state == ST_WAIT);
    assign chk.test_type  = chk.prop_valid ? prop_type : cur_type;
    assign chk.test_x     = chk.prop_valid ? prop_x    : cur_x;
    assign chk.test_y     = chk.prop_valid ? prop_y    : cur_y;

endmodule

// File: tb/tb_move_proposer.sv
// Self-checking bench for move_proposer: vector table, directed corner
// sequences and randomized moves against a simple piece model.
module tb_move_proposer;
    localparam int X_W = 4, Y_W = 5, TYPE_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        mode = 2'd1;
    logic              spawn = 1'b0;
    logic [TYPE_W-1:0] spawn_type = '0;
    logic [X_W-1:0]    spawn_x = '0;
    logic [Y_W-1:0]    spawn_y = '0;
    logic              gravity = 1'b0, tick = 1'b0;
    logic              rotate = 1'b0, left = 1'b0, right = 1'b0, down = 1'b0;
    logic [TYPE_W-1:0] cur_type;
    logic [X_W-1:0]    cur_x;
    logic [Y_W-1:0]    cur_y;
    logic              lock_pulse;

    move_proposer_if #(.X_W(X_W), .Y_W(Y_W), .TYPE_W(TYPE_W)) chk();

    move_proposer #(.X_W(X_W), .Y_W(Y_W), .TYPE_W(TYPE_W), .ROT_W(2),
                    .DAS_DLY(12), .DAS_RPT(3)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .spawn(spawn),
        .spawn_type(spawn_type), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .gravity(gravity), .tick(tick), .rotate(rotate), .left(left),
        .right(right), .down(down), .cur_type(cur_type), .cur_x(cur_x),
        .cur_y(cur_y), .lock_pulse(lock_pulse), .chk(chk)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int m_type, m_x, m_y;  // model of the committed piece

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_spawn(input int t, input int x, input int y);
        spawn_type = TYPE_W'(t);
        spawn_x    = X_W'(x);
        spawn_y    = Y_W'(y);
        spawn      = 1'b1;
        tick_clk();
        spawn  = 1'b0;
        m_type = t; m_x = x; m_y = y;
    endtask

    // bit0 grav, bit1 rot, bit2 left, bit3 right, bit4 down
    task automatic press(input logic [4:0] mask);
        gravity = mask[0]; rotate = mask[1]; left = mask[2]; right = mask[3]; down = mask[4];
        tick_clk();
        gravity = 1'b0; rotate = 1'b0; left = 1'b0; right = 1'b0; down = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!chk.prop_valid && n < 20) begin
            tick_clk();
            n++;
        end
        check(name, {31'd0, chk.prop_valid}, 32'd1);
    endtask

    task automatic serve(input bit ok, input bit exp_lock, input string name);
        chk.chk_done = 1'b1;
        chk.chk_ok   = ok;
        tick_clk();
        chk.chk_done = 1'b0;
        chk.chk_ok   = 1'b0;
        check({name, " valid_drop"}, {31'd0, chk.prop_valid}, 32'd0);
        check({name, " lock"}, {31'd0, lock_pulse}, {31'd0, exp_lock});
        tick_clk();
        check({name, " lock_after"}, {31'd0, lock_pulse}, 32'd0);
    endtask

    // Model: apply move mv to the committed piece, compare proposal, verdict, commit.
    task automatic run_move(input int mv, input bit ok, input string name);
        int t, x, y;
        t = m_type; x = m_x; y = m_y;
        case (mv)
            0, 4: y = (y + 1) % (1 << Y_W);
            1:    t = (t & ~3) | ((t + 1) & 3);
            2:    x = (x + (1 << X_W) - 1) % (1 << X_W);
            3:    x = (x + 1) % (1 << X_W);
            default: ;
        endcase
        wait_valid({name, " valid"});
        check({name, " test_type"}, 32'(chk.test_type), 32'(t));
        check({name, " test_x"}, 32'(chk.test_x), 32'(x));
        check({name, " test_y"}, 32'(chk.test_y), 32'(y));
        serve(ok, !ok && (mv == 0 || mv == 4), name);
        if (ok) begin
            m_type = t; m_x = x; m_y = y;
        end
        check({name, " cur_type"}, 32'(cur_type), 32'(m_type));
        check({name, " cur_x"}, 32'(cur_x), 32'(m_x));
        check({name, " cur_y"}, 32'(cur_y), 32'(m_y));
        check({name, " idle_test_x"}, 32'(chk.test_x), 32'(m_x));
    endtask

    typedef struct {
        logic [4:0] st; logic [3:0] sx; logic [4:0] sy;
        logic [4:0] mask; bit ok;
        logic [4:0] et; logic [3:0] ex; logic [4:0] ey; bit elock;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        chk.chk_done = 1'b0;
        chk.chk_ok   = 1'b0;
        vecs[0] = '{5'h04, 4'd3,  5'd0,  5'b00100, 1'b1, 5'h04, 4'd2,  5'd0,  1'b0};
        vecs[1] = '{5'h07, 4'd5,  5'd5,  5'b00010, 1'b1, 5'h04, 4'd5,  5'd5,  1'b0};
        vecs[2] = '{5'h04, 4'd5,  5'd19, 5'b00001, 1'b0, 5'h04, 4'd5,  5'd20, 1'b1};
        vecs[3] = '{5'h02, 4'd0,  5'd4,  5'b00100, 1'b1, 5'h02, 4'd15, 5'd4,  1'b0};
        vecs[4] = '{5'h02, 4'd15, 5'd4,  5'b01000, 1'b1, 5'h02, 4'd0,  5'd4,  1'b0};
        vecs[5] = '{5'h09, 4'd6,  5'd31, 5'b10000, 1'b1, 5'h09, 4'd6,  5'd0,  1'b0};
        vecs[6] = '{5'h09, 4'd6,  5'd7,  5'b10000, 1'b0, 5'h09, 4'd6,  5'd8,  1'b1};
        vecs[7] = '{5'h03, 4'd9,  5'd2,  5'b00100, 1'b0, 5'h03, 4'd8,  5'd2,  1'b0};
        vecs[8] = '{5'h1e, 4'd1,  5'd1,  5'b00010, 1'b0, 5'h1f, 4'd1,  5'd1,  1'b0};
        vecs[9] = '{5'h13, 4'd1,  5'd1,  5'b00010, 1'b1, 5'h10, 4'd1,  5'd1,  1'b0};

        // Reset state
        #12;
        check("rst cur_type", 32'(cur_type), 0);
        check("rst cur_x", 32'(cur_x), 0);
        check("rst cur_y", 32'(cur_y), 0);
        check("rst test_y", 32'(chk.test_y), 0);
        check("rst prop_valid", {31'd0, chk.prop_valid}, 0);
        check("rst lock", {31'd0, lock_pulse}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick_clk();

        // Vector table: one move per spawned piece
        for (int i = 0; i < 10; i++) begin
            do_spawn(int'(vecs[i].st), int'(vecs[i].sx), int'(vecs[i].sy));
            check($sformatf("vec%0d spawn_x", i), 32'(cur_x), 32'(vecs[i].sx));
            press(vecs[i].mask);
            wait_valid($sformatf("vec%0d valid", i));
            check($sformatf("vec%0d test_type", i), 32'(chk.test_type), 32'(vecs[i].et));
            check($sformatf("vec%0d test_x", i), 32'(chk.test_x), 32'(vecs[i].ex));
            check($sformatf("vec%0d test_y", i), 32'(chk.test_y), 32'(vecs[i].ey));
            serve(vecs[i].ok, vecs[i].elock, $sformatf("vec%0d", i));
            check($sformatf("vec%0d cur_type", i), 32'(cur_type), vecs[i].ok ? 32'(vecs[i].et) : 32'(vecs[i].st));
            check($sformatf("vec%0d cur_x", i), 32'(cur_x), vecs[i].ok ? 32'(vecs[i].ex) : 32'(vecs[i].sx));
            check($sformatf("vec%0d cur_y", i), 32'(cur_y), vecs[i].ok ? 32'(vecs[i].ey) : 32'(vecs[i].sy));
        end

        // Latency: edge registered, then two cycles to prop_valid
        do_spawn(4, 3, 0);
        press(5'b00100);
        check("lat cyc0", {31'd0, chk.prop_valid}, 0);
        tick_clk();
        check("lat cyc1", {31'd0, chk.prop_valid}, 0);
        tick_clk();
        check("lat cyc2", {31'd0, chk.prop_valid}, 1);
        run_move(2, 1'b1, "lat");

        // Gravity and right together: gravity first
        press(5'b01001);
        run_move(0, 1'b1, "pri grav");
        run_move(3, 1'b1, "pri rgt");

        // Gravity re-asserted on the selection cycle is retained
        gravity = 1'b1;
        tick_clk();
        tick_clk();
        gravity = 1'b0;
        run_move(0, 1'b1, "keep g1");
        run_move(0, 1'b1, "keep g2");
        repeat (6) tick_clk();
        check("keep none_left", {31'd0, chk.prop_valid}, 0);

        // Verdict outside WAIT is ignored
        chk.chk_done = 1'b1;
        chk.chk_ok   = 1'b0;
        tick_clk();
        chk.chk_done = 1'b0;
        check("stray lock", {31'd0, lock_pulse}, 0);
        check("stray cur_y", 32'(cur_y), 32'(m_y));

        // Frozen mode holds requests; an outstanding WAIT still completes
        mode = 2'd0;
        press(5'b00100);
        repeat (6) tick_clk();
        check("frozen no_prop", {31'd0, chk.prop_valid}, 0);
        mode = 2'd2;
        run_move(2, 1'b1, "thaw lft");
        press(5'b01000);
        wait_valid("frz wait valid");
        mode = 2'd0;
        run_move(3, 1'b1, "frz complete");
        mode = 2'd1;

        // Spawn aborts WAIT, suppresses lock, clears queued down
        press(5'b10001);
        wait_valid("abort valid");
        spawn_type = 5'h0c; spawn_x = 4'd7; spawn_y = 5'd3;
        spawn = 1'b1;
        chk.chk_done = 1'b1;
        chk.chk_ok   = 1'b0;
        tick_clk();
        spawn = 1'b0;
        chk.chk_done = 1'b0;
        m_type = 'h0c; m_x = 7; m_y = 3;
        check("abort valid_drop", {31'd0, chk.prop_valid}, 0);
        check("abort lock", {31'd0, lock_pulse}, 0);
        check("abort cur_x", 32'(cur_x), 7);
        check("abort cur_type", 32'(cur_type), 'h0c);
        repeat (6) tick_clk();
        check("abort pend_cleared", {31'd0, chk.prop_valid}, 0);

        // Randomized multi-request bursts against the model
        for (int it = 0; it < 30; it++) begin
            logic [4:0] mask;
            if (it % 8 == 0)
                do_spawn(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), int'($urandom_range(0, 31)));
            mask = 5'($urandom_range(1, 31));
            press(mask);
            for (int mv = 0; mv < 5; mv++)
                if (mask[mv]) run_move(mv, 1'($urandom_range(0, 1)), $sformatf("rnd%0d mv%0d", it, mv));
        end
        repeat (4) tick_clk();
        check("rnd drained", {31'd0, chk.prop_valid}, 0);

`ifdef AUTO_REPEAT_EN
        // Hold right for 30 ticks, accepting every proposal
        begin
            int n_rgt = 0;
            do_spawn(4, 0, 0);
            for (int cyc = 0; cyc < 30 * 8 + 24; cyc++) begin
                right = (cyc < 30 * 8);
                tick  = (cyc % 8 == 7) && (cyc < 30 * 8);
                if (chk.prop_valid) begin
                    n_rgt++;
                    chk.chk_done = 1'b1;
                    chk.chk_ok   = 1'b1;
                end else begin
                    chk.chk_done = 1'b0;
                end
                tick_clk();
            end
            right = 1'b0; tick = 1'b0; chk.chk_done = 1'b0; chk.chk_ok = 1'b0;
            check("das count", 32'(n_rgt), 8);
            check("das cur_x", 32'(cur_x), 8);
            m_x = 8;
        end
`endif

        // Reset mid-WAIT abandons the proposal at once
        do_spawn(4, 3, 2);
        press(5'b00100);
        wait_valid("rstw valid");
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw valid_drop", {31'd0, chk.prop_valid}, 0);
        check("rstw cur_x", 32'(cur_x), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick_clk();
            check($sformatf("rstw lock%0d", k), {31'd0, lock_pulse}, 0);
            check($sformatf("rstw valid%0d", k), {31'd0, chk.prop_valid}, 0);
        end
        check("rstw cur_type", 32'(cur_type), 0);
        check("rstw cur_y", 32'(cur_y), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
